// File: rtl/i2s_tx_master.sv
// Stereo I2S / left-justified transmitter, bus master, driven from the system clock
// through a clock-enable divider, with a one-frame holding buffer on a valid/ready input.
module i2s_tx_master #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_DIV   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  en_in,
  input  logic                  fmt_in,
  input  logic                  mute_in,
  input  logic                  s_valid_in,
  output logic                  s_ready_out,
  input  logic [DATA_WIDTH-1:0] s_ldata_in,
  input  logic [DATA_WIDTH-1:0] s_rdata_in,
  output logic                  sclk_out,
  output logic                  lrck_out,
  output logic                  sdata_out,
  output logic                  frame_start_out,
  output logic                  underrun_out
);

  localparam int DCW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int BW  = $clog2(2 * SLOT_WIDTH);

  localparam logic [DCW-1:0] DIV_LAST    = DCW'(SCLK_DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF    = DCW'(SCLK_DIV / 2);
  localparam logic [BW-1:0]  BIT_LAST    = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0]  BIT_LAST_M1 = BW'(2 * SLOT_WIDTH - 2);
  localparam logic [BW-1:0]  SLOT_B      = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0]  SLOT_M1     = BW'(SLOT_WIDTH - 1);

  logic [DCW-1:0]        div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_WIDTH-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
  logic                  fmt_q, fmt_d;
  logic                  sclk_q, sclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic                  fs_q, fs_d, ur_q, ur_d;

  logic                  load, accept, left_slot;
  logic [BW-1:0]         slot_idx;
  logic [DATA_WIDTH-1:0] sample, shifted;

  assign s_ready_out = !buf_full_q;

  // NOTE: every signal written here gets a default first, otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    fmt_d      = fmt_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;

    load   = en_in && (div_q == '0) && (bit_q == '0);
    accept = s_valid_in && !buf_full_q;

    if (!en_in) begin
      div_d = '0;
      bit_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (div_q == DIV_LAST) bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    end

    // A load always wins over a buffer write: an incoming frame on a load cycle
    // with an empty buffer goes straight to the shifter.
    if (load) begin
      fmt_d = fmt_in;
      if (buf_full_q) begin
        frm_l_d    = buf_l_q;
        frm_r_d    = buf_r_q;
        buf_full_d = 1'b0;
      end else if (s_valid_in) begin
        frm_l_d = s_ldata_in;
        frm_r_d = s_rdata_in;
      end else begin
        frm_l_d = '0;
        frm_r_d = '0;
      end
      if (mute_in) begin
        frm_l_d = '0;
        frm_r_d = '0;
      end
    end else if (accept) begin
      buf_l_d    = s_ldata_in;
      buf_r_d    = s_rdata_in;
      buf_full_d = 1'b1;
    end

    left_slot = (bit_q < SLOT_B);
    slot_idx  = left_slot ? bit_q : bit_q - SLOT_B;
    sample    = left_slot ? frm_l_d : frm_r_d;
    shifted   = sample << slot_idx;  // pad bits shift in as zeros

    sclk_d = en_in && (div_q >= DIV_HALF);
    if (!en_in) begin
      lrck_d  = 1'b0;
      sdata_d = 1'b0;
    end else if (div_q == '0) begin
      sdata_d = shifted[DATA_WIDTH-1];
      lrck_d  = fmt_d ? (bit_q >= SLOT_B)
                      : ((bit_q >= SLOT_M1) && (bit_q <= BIT_LAST_M1));
    end

    fs_d = load;
    ur_d = load && !buf_full_q && !s_valid_in;
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      bit_q      <= '0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
      fmt_q      <= 1'b0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
      fmt_q      <= fmt_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign sclk_out        = sclk_q;
  assign lrck_out        = lrck_q;
  assign sdata_out       = sdata_q;
  assign frame_start_out = fs_q;
  assign underrun_out    = ur_q;

endmodule
